// File: rtl/pi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_ctrl_pkg
//  Description : Shared types and helpers for the phase-interpolator code
//                controller: the slew FSM state type, a signed modular
//                difference helper and an index-to-one-hot helper.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package pi_ctrl_pkg;

   typedef enum logic [0:0] {
      PI_SETTLED = 1'b0,
      PI_SLEW    = 1'b1
   } pi_state_e;

   // Signed difference (a - b) modulo 2^w, sign-extended to 32 bits.
   // The half-range value -2^(w-1) comes out negative, which makes a
   // half-turn target move downward.
   function automatic logic signed [31:0] pi_wrap_diff(
      input logic [31:0] a,
      input logic [31:0] b,
      input int unsigned w
   );
      logic [31:0] raw;
      logic [31:0] mask;
      raw  = a - b;
      mask = (32'd1 << w) - 32'd1;
      if (((raw >> (w - 32'd1)) & 32'd1) != 32'd0) begin
         return $signed(raw | ~mask);
      end
      return $signed(raw & mask);
   endfunction

   // Index to one-hot; callers keep the low NUM_PHASES bits.
   function automatic logic [63:0] pi_onehot(input logic [5:0] idx);
      return 64'd1 << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pi_freq_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : pi_freq_integrator
//  Description : Second-order (frequency) path of the interpolator code
//                controller. Only instantiated when PI_FREQ_ACC_EN is defined.
//                freq_int integrates up/dn votes with symmetric saturation;
//                on every tick frac_acc accumulates freq_int and reports a
//                wrap as a one-cycle carry (upward) or borrow (downward).
//  Ports       : CLK, rst_n       - clock, asynchronous active-low reset
//                up, dn           - phase votes
//                tick             - update tick from the controller
//                clear            - accepted code load; clears frac_acc
//                freq_int         - integrator value (two's complement)
//                carry, borrow    - +1 / -1 requests for the target code
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_freq_integrator #(
   parameter int FREQ_W = 12,
   parameter int FRAC_W = 8
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              up,
   input  logic              dn,
   input  logic              tick,
   input  logic              clear,
   output logic [FREQ_W-1:0] freq_int,
   output logic              carry,
   output logic              borrow
);

   localparam int c_FREQ_MAX = (1 << (FREQ_W - 1)) - 1;
   localparam int c_FRAC_MOD = 1 << FRAC_W;

   logic signed [FREQ_W-1:0] r_freq;
   logic        [FRAC_W-1:0] r_frac;
   int                       w_fsum;
   int                       w_asum;

   always_comb begin
      w_fsum = int'(r_freq);
      if (up && !dn) begin
         w_fsum = w_fsum + 1;
      end else if (dn && !up) begin
         w_fsum = w_fsum - 1;
      end
      // Symmetric clamp keeps the most negative code unused.
      if (w_fsum > c_FREQ_MAX) begin
         w_fsum = c_FREQ_MAX;
      end else if (w_fsum < -c_FREQ_MAX) begin
         w_fsum = -c_FREQ_MAX;
      end
      w_asum = int'(r_frac) + int'(r_freq);
   end

   assign carry    = tick && !clear && (w_asum >= c_FRAC_MOD);
   assign borrow   = tick && !clear && (w_asum < 0);
   assign freq_int = r_freq;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_freq <= '0;
         r_frac <= '0;
      end else begin
         r_freq <= FREQ_W'(w_fsum);
         if (clear) begin
            r_frac <= '0;
         end else if (tick) begin
            r_frac <= FRAC_W'(w_asum);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pi_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pi_code_ctrl
//  Description : Phase-interpolator code controller. Converts up/dn phase
//                votes and absolute code loads into a slew-limited,
//                wrap-around interpolator code, and decodes it into mixer
//                phase selects plus complementary weights.
//                Optional second-order frequency path: define PI_FREQ_ACC_EN.
//  Ports       : CLK, rst_n                 - clock, async active-low reset
//                load_valid/load_code/load_ready - absolute code load
//                up, dn                      - one-cycle target votes
//                code_out, code_valid        - applied code, change pulse
//                phase_sel_a, phase_sel_b    - one-hot mixer phase selects
//                weight_a, weight_b          - complementary weights
//                settled                     - applied code equals target
//                freq_mon                    - frequency integrator (or 0)
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module pi_code_ctrl
   import pi_ctrl_pkg::*;
#(
   parameter  int NUM_PHASES = 8,
   parameter  int WEIGHT_W   = 8,
   parameter  int MAX_STEP   = 4,
   parameter  int UPD_DIV    = 4,
   parameter  int FREQ_W     = 12,
   parameter  int FRAC_W     = 8,
   localparam int CODE_W     = $clog2(NUM_PHASES) + WEIGHT_W
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  load_valid,
   input  logic [CODE_W-1:0]     load_code,
   output logic                  load_ready,
   input  logic                  up,
   input  logic                  dn,
   output logic [CODE_W-1:0]     code_out,
   output logic                  code_valid,
   output logic [NUM_PHASES-1:0] phase_sel_a,
   output logic [NUM_PHASES-1:0] phase_sel_b,
   output logic [WEIGHT_W-1:0]   weight_a,
   output logic [WEIGHT_W-1:0]   weight_b,
   output logic                  settled,
   output logic [FREQ_W-1:0]     freq_mon
);

   localparam int c_PH_W  = $clog2(NUM_PHASES);
   localparam int c_CNT_W = $clog2(UPD_DIV);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if ((NUM_PHASES < 4) || (NUM_PHASES > 64) ||
       ((NUM_PHASES & (NUM_PHASES - 1)) != 0)) begin : g_chk_phases
      $error("NUM_PHASES must be a power of 2 in 4..64");
   end
   if (UPD_DIV < 2) begin : g_chk_div
      $error("UPD_DIV must be at least 2");
   end
   if ((MAX_STEP < 1) || (MAX_STEP >= (1 << (CODE_W - 1)))) begin : g_chk_step
      $error("MAX_STEP must be in 1..2^(CODE_W-1)-1");
   end
   if ((FRAC_W < 1) || (FRAC_W > 30) || (FREQ_W < 2) || (FREQ_W > 30)) begin : g_chk_freq
      $error("FREQ_W/FRAC_W out of range");
   end

   // ------------------------------------------------------------------------
   // Registers and next-state wires
   // ------------------------------------------------------------------------
   logic [CODE_W-1:0]  r_target;
   logic [CODE_W-1:0]  r_applied;
   logic [c_CNT_W-1:0] r_tick_cnt;
   pi_state_e          r_state;
   logic               r_code_valid;

   logic [CODE_W-1:0]  w_target_nxt;
   logic [CODE_W-1:0]  w_applied_nxt;
   pi_state_e          w_state_nxt;
   logic               w_tick;
   logic               w_load_acc;
   logic signed [31:0] w_diff;
   logic signed [31:0] w_step;
   logic signed [2:0]  w_delta;
   logic               w_carry;
   logic               w_borrow;
   logic [c_PH_W-1:0]  w_ph_a;
   logic [c_PH_W-1:0]  w_ph_b;

   assign w_tick     = (r_tick_cnt == c_CNT_W'(UPD_DIV - 1));
   assign load_ready = (r_state == PI_SETTLED);
   assign w_load_acc = load_valid && load_ready;

   // ------------------------------------------------------------------------
   // Optional frequency path
   // ------------------------------------------------------------------------
`ifdef PI_FREQ_ACC_EN
   logic [FREQ_W-1:0] w_freq_int;

   pi_freq_integrator #(
      .FREQ_W (FREQ_W),
      .FRAC_W (FRAC_W)
   ) u_freq (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .up       (up),
      .dn       (dn),
      .tick     (w_tick),
      .clear    (w_load_acc),
      .freq_int (w_freq_int),
      .carry    (w_carry),
      .borrow   (w_borrow)
   );

   assign freq_mon = w_freq_int;
`else
   assign w_carry  = 1'b0;
   assign w_borrow = 1'b0;
   assign freq_mon = '0;
`endif

   // ------------------------------------------------------------------------
   // Target update: a load wins and drops same-cycle votes; otherwise the
   // votes and any accumulator carry/borrow are summed (net range +-2).
   // ------------------------------------------------------------------------
   always_comb begin
      w_delta = 3'sd0;
      if (up && !dn) begin
         w_delta = 3'sd1;
      end else if (dn && !up) begin
         w_delta = -3'sd1;
      end
      if (w_carry) begin
         w_delta = w_delta + 3'sd1;
      end
      if (w_borrow) begin
         w_delta = w_delta - 3'sd1;
      end

      if (w_load_acc) begin
         w_target_nxt = load_code;
      end else begin
         w_target_nxt = r_target + {{(CODE_W-3){w_delta[2]}}, w_delta};
      end
   end

   // ------------------------------------------------------------------------
   // Slew: on a tick move applied toward the pre-edge target by at most
   // MAX_STEP along the shorter way round the code circle.
   // ------------------------------------------------------------------------
   assign w_diff = pi_wrap_diff(32'(r_target), 32'(r_applied), CODE_W);

   always_comb begin
      if (w_diff > MAX_STEP) begin
         w_step = MAX_STEP;
      end else if (w_diff < -MAX_STEP) begin
         w_step = -MAX_STEP;
      end else begin
         w_step = w_diff;
      end
      w_applied_nxt = w_tick ? (r_applied + CODE_W'(w_step)) : r_applied;
   end

   // ------------------------------------------------------------------------
   // FSM next state. Leaving SETTLED looks at the post-edge codes so that
   // load_ready drops together with settled; returning needs a tick.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PI_SETTLED: begin
            if (w_target_nxt != w_applied_nxt) begin
               w_state_nxt = PI_SLEW;
            end
         end
         PI_SLEW: begin
            if (w_tick && (w_target_nxt == w_applied_nxt)) begin
               w_state_nxt = PI_SETTLED;
            end
         end
         default: w_state_nxt = PI_SETTLED;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_target     <= '0;
         r_applied    <= '0;
         r_tick_cnt   <= '0;
         r_state      <= PI_SETTLED;
         r_code_valid <= 1'b0;
      end else begin
         r_target     <= w_target_nxt;
         r_applied    <= w_applied_nxt;
         r_tick_cnt   <= w_tick ? '0 : (r_tick_cnt + c_CNT_W'(1));
         r_state      <= w_state_nxt;
         r_code_valid <= (w_applied_nxt != r_applied);
      end
   end

   // ------------------------------------------------------------------------
   // Output decode (combinational from the applied code)
   // ------------------------------------------------------------------------
   assign code_out    = r_applied;
   assign code_valid  = r_code_valid;
   assign settled     = (r_applied == r_target);
   assign w_ph_a      = r_applied[CODE_W-1:WEIGHT_W];
   assign w_ph_b      = w_ph_a + c_PH_W'(1);   // wraps to phase 0 past the top
   assign phase_sel_a = NUM_PHASES'(pi_onehot(6'(w_ph_a)));
   assign phase_sel_b = NUM_PHASES'(pi_onehot(6'(w_ph_b)));
   assign weight_b    = r_applied[WEIGHT_W-1:0];
   assign weight_a    = ~weight_b;

endmodule
`default_nettype wire

// File: tb/tb_pi_code_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_code_ctrl
//  Description : Self-checking bench for pi_code_ctrl (default build).
//                Expected code_out values are produced by a slew model and
//                queued when a load/vote is driven, then popped and compared
//                on every code_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_code_ctrl;

   localparam int NUM_PHASES = 8;
   localparam int WEIGHT_W   = 8;
   localparam int MAX_STEP   = 4;
   localparam int UPD_DIV    = 4;
   localparam int FREQ_W     = 12;
   localparam int FRAC_W     = 8;
   localparam int CODE_W     = 11;
   localparam int c_MASK     = (1 << CODE_W) - 1;
   localparam int c_HALF     = 1 << (CODE_W - 1);

   logic                  CLK = 1'b0;
   logic                  rst_n;
   logic                  load_valid;
   logic [CODE_W-1:0]     load_code;
   logic                  load_ready;
   logic                  up;
   logic                  dn;
   logic [CODE_W-1:0]     code_out;
   logic                  code_valid;
   logic [NUM_PHASES-1:0] phase_sel_a;
   logic [NUM_PHASES-1:0] phase_sel_b;
   logic [WEIGHT_W-1:0]   weight_a;
   logic [WEIGHT_W-1:0]   weight_b;
   logic                  settled;
   logic [FREQ_W-1:0]     freq_mon;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   pi_code_ctrl #(
      .NUM_PHASES (NUM_PHASES),
      .WEIGHT_W   (WEIGHT_W),
      .MAX_STEP   (MAX_STEP),
      .UPD_DIV    (UPD_DIV),
      .FREQ_W     (FREQ_W),
      .FRAC_W     (FRAC_W)
   ) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_code   (load_code),
      .load_ready  (load_ready),
      .up          (up),
      .dn          (dn),
      .code_out    (code_out),
      .code_valid  (code_valid),
      .phase_sel_a (phase_sel_a),
      .phase_sel_b (phase_sel_b),
      .weight_a    (weight_a),
      .weight_b    (weight_b),
      .settled     (settled),
      .freq_mon    (freq_mon)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference slew: shortest way round, half range goes down, clamp to MAX_STEP.
   task automatic push_slew(input int from, input int to, input int maxn);
      int a;
      int d;
      int n;
      a = from;
      n = 0;
      while ((a != to) && (n < maxn)) begin
         d = (to - a) & c_MASK;
         if (d >= c_HALF) d = d - (c_MASK + 1);
         if (d > MAX_STEP) d = MAX_STEP;
         else if (d < -MAX_STEP) d = -MAX_STEP;
         a = (a + d) & c_MASK;
         exp_q.push_back(a);
         n++;
      end
   endtask

   task automatic drain(input int budget, input bit chk_ready);
      int n;
      int e;
      n = 0;
      while ((exp_q.size() > 0) && (n < budget)) begin
         @(negedge CLK);
         n++;
         if (code_valid) begin
            e = exp_q.pop_front();
            chk("slew_code", 32'(code_out), e);
         end
         if (chk_ready) chk("ready_during_slew", 32'(load_ready), (exp_q.size() == 0) ? 1 : 0);
      end
      chk("slew_steps_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk("idle_no_valid", 32'(code_valid), 0);
      end
   endtask

   task automatic do_load(input logic [CODE_W-1:0] c, input logic u);
      @(negedge CLK);
      load_valid = 1'b1;
      load_code  = c;
      up         = u;
      @(negedge CLK);
      load_valid = 1'b0;
      up         = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_code"},     32'(code_out),    0);
      chk({tag, "_valid"},    32'(code_valid),  0);
      chk({tag, "_sel_a"},    32'(phase_sel_a), 32'h01);
      chk({tag, "_sel_b"},    32'(phase_sel_b), 32'h02);
      chk({tag, "_weight_b"}, 32'(weight_b),    32'h00);
      chk({tag, "_weight_a"}, 32'(weight_a),    32'hFF);
      chk({tag, "_ready"},    32'(load_ready),  1);
      chk({tag, "_settled"},  32'(settled),     1);
      chk({tag, "_freq_mon"}, 32'(freq_mon),    0);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_code  = '0;
      up         = 1'b0;
      dn         = 1'b0;

      // Reset values
      repeat (3) @(negedge CLK);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Load 0x180 from 0: 96 ticks of +4
      do_load(11'h180, 1'b0);
      chk("load_settled_low", 32'(settled), 0);
      chk("load_ready_low", 32'(load_ready), 0);
      push_slew(0, 'h180, 1000);
      drain(96 * UPD_DIV + 8, 1'b1);
      chk("b_code", 32'(code_out), 32'h180);
      chk("b_sel_a", 32'(phase_sel_a), 32'h02);
      chk("b_sel_b", 32'(phase_sel_b), 32'h04);
      chk("b_weight_b", 32'(weight_b), 32'h80);
      chk("b_weight_a", 32'(weight_a), 32'h7F);
      chk("b_settled", 32'(settled), 1);
      idle(6);

      // Load 0x010 together with up: up dropped, slew down to exactly 0x010
      do_load(11'h010, 1'b1);
      push_slew('h180, 'h010, 1000);
      drain(100 * UPD_DIV, 1'b0);
      chk("c_code", 32'(code_out), 32'h010);
      chk("c_settled", 32'(settled), 1);

      // up and dn together: no-op
      @(negedge CLK);
      up = 1'b1;
      dn = 1'b1;
      @(negedge CLK);
      up = 1'b0;
      dn = 1'b0;
      chk("updn_settled", 32'(settled), 1);
      chk("updn_ready", 32'(load_ready), 1);
      idle(12);
      chk("updn_code", 32'(code_out), 32'h010);

      // Reset mid-slew: code_out returns to 0 at once
      do_load(11'h400, 1'b0);
      push_slew('h010, 'h400, 5);
      drain(5 * UPD_DIV + 8, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(negedge CLK);

      // Release with a load of 2046: first tick exactly UPD_DIV clocks later
      rst_n      = 1'b1;
      load_valid = 1'b1;
      load_code  = 11'd2046;
      for (int i = 1; i <= UPD_DIV; i++) begin
         @(negedge CLK);
         if (i == 1) begin
            load_valid = 1'b0;
            chk("wrap_settled_low", 32'(settled), 0);
         end
         if (i < UPD_DIV) begin
            chk("wrap_pre_tick_valid", 32'(code_valid), 0);
            chk("wrap_pre_tick_code", 32'(code_out), 0);
         end
      end
      chk("wrap_tick_valid", 32'(code_valid), 1);
      chk("wrap_code", 32'(code_out), 2046);
      chk("wrap_sel_a", 32'(phase_sel_a), 32'h80);
      chk("wrap_sel_b", 32'(phase_sel_b), 32'h01);
      chk("wrap_weight_b", 32'(weight_b), 32'hFE);
      chk("wrap_weight_a", 32'(weight_a), 32'h01);
      chk("wrap_settled", 32'(settled), 1);

      // Three up pulses before the next tick: one +3 step across the wrap
      up = 1'b1;
      @(negedge CLK);
      chk("up3_no_valid", 32'(code_valid), 0);
      chk("up3_settled_low", 32'(settled), 0);
      @(negedge CLK);
      @(negedge CLK);
      up = 1'b0;
      exp_q.push_back(1);
      drain(3 * UPD_DIV, 1'b0);
      chk("up3_code", 32'(code_out), 1);
      chk("up3_sel_a", 32'(phase_sel_a), 32'h01);
      chk("up3_sel_b", 32'(phase_sel_b), 32'h02);
      chk("up3_settled", 32'(settled), 1);
      idle(8);

      // Half range from 0: first step goes down to 2044
      @(negedge CLK);
      rst_n = 1'b0;
      @(negedge CLK);
      chk("half_reset_code", 32'(code_out), 0);
      rst_n = 1'b1;
      do_load(11'h400, 1'b0);
      push_slew(0, 'h400, 1000);
      chk("half_first_model", exp_q[0], 2044);
      drain(256 * UPD_DIV + 8, 1'b1);
      chk("half_code", 32'(code_out), 32'h400);
      chk("half_settled", 32'(settled), 1);
      chk("half_ready", 32'(load_ready), 1);
      chk("half_sel_a", 32'(phase_sel_a), 32'h10);
      chk("half_sel_b", 32'(phase_sel_b), 32'h20);
      chk("half_weight_a", 32'(weight_a), 32'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pi_code_ctrl.md
# pi_code_ctrl

Synthesizable phase-interpolator code controller for the CDR path: converts up/down phase votes and absolute code loads into a slew-limited, wrap-around interpolator code. Drives NUM_PHASES-phase mixer selects plus complementary weights. Parametrised successor of the 8-phase, 11-bit behavioural mixer code interface. Sits between the CDR loop filter and the phase mixer.

## Interface
- NUM_PHASES, 8: mixer input phases; power of 2, at least 4.
- WEIGHT_W, 8: interpolation weight bits.
- CODE_W, $clog2(NUM_PHASES)+WEIGHT_W: code width; derived, not overridable.
- MAX_STEP, 4: maximum code LSBs moved per update tick.
- UPD_DIV, 4: clocks per update tick, at least 2.
- FREQ_W, 12: signed frequency integrator width. Used only with the frequency path.
- FRAC_W, 8: fractional phase accumulator width. Used only with the frequency path.
- CLK  in  1  block clock. One clock only.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  absolute code load request.
- load_code  in  CODE_W  code to load.
- load_ready  out  1  high when state is SETTLED.
- up  in  1  one-cycle vote: target +1.
- dn  in  1  one-cycle vote: target −1.
- code_out  out  CODE_W  applied code.
- code_valid  out  1  one-cycle pulse when code_out changes.
- phase_sel_a  out  NUM_PHASES  one-hot select of phase code_out[CODE_W-1:WEIGHT_W].
- phase_sel_b  out  NUM_PHASES  one-hot select of the next phase, modulo NUM_PHASES.
- weight_b  out  WEIGHT_W  equals code_out[WEIGHT_W-1:0].
- weight_a  out  WEIGHT_W  equals (2^WEIGHT_W−1) − weight_b.
- settled  out  1  high when applied code equals target.
- freq_mon  out  FREQ_W  frequency integrator value. Tied to 0 without the frequency path.

## Operation
- Registers:
  - target and applied, both CODE_W, modulo 2^CODE_W.
  - tick counter, 0..UPD_DIV−1.
  - state {SETTLED, SLEW}.
- Target update, with priority:
  - An accepted load (load_valid & load_ready) sets target = load_code. Any up/dn in the same cycle is dropped.
  - Otherwise up alone adds 1 and dn alone subtracts 1; up&dn together is a no-op.
  - up/dn have no handshake and are accepted in both states.
- Tick: asserted when the counter equals UPD_DIV−1. The counter free-runs.
- On each tick:
  - diff = (target − applied) mod 2^CODE_W, read as signed CODE_W.
  - Exactly −2^(CODE_W−1) (half range) counts as negative.
  - Step = diff clamped to ±MAX_STEP; applied += step, wrapping.
- State transitions:
  - SETTLED→SLEW when target ≠ applied.
  - SLEW→SETTLED when they are equal after a tick.
- Wrap-around: 2^CODE_W−1 +1 → 0. phase_sel_a moves from the top phase to bit 0, and phase_sel_b from bit 0 to bit 1.
- A tick coinciding with a target change uses the pre-edge target.

## Timing
- code_out, code_valid and state are registered. Selects and weights are combinational from code_out.
- Values after reset:
  - target = applied = 0, counter 0, SETTLED.
  - code_valid 0, phase_sel_a bit0, phase_sel_b bit1.
  - weight_b 0, weight_a all ones.
  - load_ready 1, settled 1, freq_mon 0.
- Reset mid-slew clears all state at once. No tick occurs until UPD_DIV clocks after release.
- Latency:
  - A load is visible in target on the next edge.
  - The first code_out change occurs at the next tick edge; code_valid is high in the cycle after that edge.
- Settling time is ceil(|diff|/MAX_STEP) ticks.
- settled and load_ready fall in the cycle after target diverges from applied.

## Configuration
- PI_FREQ_ACC_EN defined, second-order path:
  - freq_int += up − dn, saturating at ±(2^(FREQ_W−1)−1).
  - Each tick: frac_acc(FRAC_W) += sign-extended freq_int.
  - A carry adds +1 to target and a borrow adds −1, summed with same-cycle up/dn. Net range is ±2.
  - A load clears frac_acc but keeps freq_int.
  - freq_mon = freq_int.
- PI_FREQ_ACC_EN undefined: no integrator or accumulator logic, and freq_mon = 0.

## Structure
- Package pi_ctrl_pkg holds:
  - the state enum pi_state_e {PI_SETTLED, PI_SLEW};
  - function pi_wrap_diff (signed modular difference);
  - function pi_onehot (index to one-hot).
- Sub-module pi_freq_integrator holds freq_int and frac_acc. It is instantiated only under PI_FREQ_ACC_EN and outputs carry and borrow.

## Test plan
- Reset: check every value listed under Timing. Assert rst_n mid-slew and check that code_out returns to 0 at once.
- Load 0x180 from 0: expect 96 ticks of +4, ending with code_out=0x180, phase_sel_a=0x02, phase_sel_b=0x04, weight_b=0x80, weight_a=0x7F, settled=1.
- Wrap:
  - Load 2046 from 0: expect one −2 step, then phase_sel_a=0x80 and phase_sel_b=0x01.
  - Then three up pulses: expect a single +3 tick to code_out=1.
- Half range: load 1024 from 0. Expect the first tick to give 2044 (downward), with load_ready held low until settled.
- Same-cycle events:
  - up&dn together: target unchanged.
  - load 0x010 together with up: target=0x010.
- PI_FREQ_ACC_EN: 16 up pulses give freq_mon=16 and target +16. After settling, target then drifts +1 every 16 ticks (64 clocks).
